stack_queue_buffer: RTL

Parametrised successor to the single-width stack/queue memory unit. It provides one storage array that runs as a LIFO stack or a FIFO queue, with a configurable data width and depth. Over the earlier unit it adds an occupancy count, an almost-full flag, a synchronous clear, defined simultaneous push/pop semantics, overflow/underflow error pulses and safe deferred mode switching. It sits between the memory controller (push/pop/data_in) and the seven-segment/ALU datapath (data_out).

---
 rtl/stack_queue_buffer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stack_queue_buffer.sv
// stack_queue_buffer: one storage array that acts as a LIFO stack or a FIFO
// queue. It provides an occupancy count, status flags, a synchronous clear,
// push/pop error pulses, and a mode switch that waits until the buffer is empty.
module stack_queue_buffer #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             pop_valid,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             mode_active,
    output logic             overflow_err,
    output logic             underflow_err
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {
        MODE_STACK = 1'b0,
        MODE_QUEUE = 1'b1
    } mode_e;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_data_out;
    logic             r_pop_valid;
    logic             r_overflow;
    logic             r_underflow;
    mode_e            r_mode_active;

    logic             w_empty;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic             w_push_rej;
    logic             w_pop_rej;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // A pop is accepted whenever data is present. A push is accepted when the
    // buffer has room, or when a pop in the same cycle frees a slot.
    assign w_pop_ok    = pop && !clear && !w_empty;
    assign w_push_ok   = push && !clear && (!w_full || w_pop_ok);
    assign w_pop_rej   = pop && !clear && w_empty;
    assign w_push_rej  = push && !clear && !w_push_ok;
    assign w_count_nxt = r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop_ok);

    // Slot selection: the stack addresses entries by occupancy, and the queue
    // uses its own pointers. When the buffer is empty, both modes write slot 0
    // because the pointers are being re-zeroed on that same edge.
    always_comb begin
        // NOTE: every always_comb output is assigned a default first, so no path can infer a latch.
        w_top_idx = PTR_W'(r_count - CNT_W'(1));
        w_rd_idx  = r_rd_ptr;
        w_wr_idx  = r_wr_ptr;
        if (w_empty) begin
            w_wr_idx = '0;
        end else if (r_mode_active == MODE_STACK) begin
            w_rd_idx = w_top_idx;
            w_wr_idx = w_pop_ok ? w_top_idx : PTR_W'(r_count);
        end
    end

    // Storage array write port.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset. Its contents only become meaningful through count, so resetting it would be wasted logic.
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= data_in;
        end
    end

    // Control state: occupancy, pointers, active mode, read data and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every read in this block sees pre-edge values.
        if (!rst) begin
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_data_out    <= '0;
            r_pop_valid   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_mode_active <= MODE_STACK;
        end else begin
            if (w_empty) begin
                r_mode_active <= mode_e'(mode);
            end
            if (clear) begin
                r_count     <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_data_out  <= '0;
                r_pop_valid <= 1'b0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                r_count     <= w_count_nxt;
                r_pop_valid <= w_pop_ok;
                r_overflow  <= w_push_rej;
                r_underflow <= w_pop_rej;
                if (w_pop_ok) begin
                    r_data_out <= r_mem[w_rd_idx];
                end
                if (w_empty) begin
                    r_wr_ptr <= w_push_ok ? PTR_W'(1) : '0;
                    r_rd_ptr <= '0;
                end else if (r_mode_active == MODE_QUEUE) begin
                    if (w_push_ok) begin
                        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    end
                    if (w_pop_ok) begin
                        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    end
                end
            end
        end
    end

    assign data_out      = r_data_out;
    assign pop_valid     = r_pop_valid;
    assign count         = r_count;
    assign empty         = w_empty;
    assign full          = w_full;
    assign almost_full   = (r_count >= CNT_W'(AF_LEVEL));
    assign mode_active   = r_mode_active;
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

endmodule
